// File: rtl/instr_encoder.sv
// Packs decoded instruction fields into 32-bit words and queues them in a small output FIFO.
// Optional macro INSTR_ENCODER_CMP_FIXUP_EN forces S=1 and Rd=0 on data-processing compares.
module instr_encoder #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [3:0]       in_cond,
    input  logic             in_imm_sel,
    input  logic [3:0]       in_cmd,
    input  logic             in_set,
    input  logic [3:0]       in_rn,
    input  logic [3:0]       in_rd,
    input  logic [11:0]      in_imm12,
    input  logic [3:0]       in_rm,
    input  logic [23:0]      in_offset,
    output logic [31:0]      instr,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic             err_illegal,
    output logic [CNT_W-1:0] instr_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

    logic [31:0]      r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_occ;
    logic             r_err;
    logic [CNT_W-1:0] r_count;

    logic        w_accept;
    logic        w_legal;
    logic        w_push;
    logic        w_pop;
    logic        w_set;
    logic [3:0]  w_rd;
    logic [11:0] w_operand;
    logic [31:0] w_word;

    assign in_ready    = (r_occ != FULL_OCC);
    assign instr_valid = (r_occ != '0);
    assign instr       = instr_valid ? r_mem[r_rd_ptr] : 32'h0;
    assign err_illegal = r_err;
    assign instr_count = r_count;

    assign w_accept = in_valid && in_ready;
    assign w_legal  = (in_op != 2'd3);
    assign w_push   = w_accept && w_legal;
    assign w_pop    = instr_valid && instr_ready;

`ifdef INSTR_ENCODER_CMP_FIXUP_EN
    // Compares never write back, so the decoder expects S set and Rd cleared.
    logic w_is_cmp;
    assign w_is_cmp = (in_op == 2'd0) && (in_cmd == 4'd10);
    assign w_set    = w_is_cmp ? 1'b1 : in_set;
    assign w_rd     = w_is_cmp ? 4'd0 : in_rd;
`else
    assign w_set    = in_set;
    assign w_rd     = in_rd;
`endif

    assign w_operand = in_imm_sel ? in_imm12 : {8'h00, in_rm};

    always_comb begin
        w_word = {in_cond, in_op, in_imm_sel, in_cmd, w_set, in_rn, w_rd, w_operand};
        if (in_op == 2'd2) begin
            w_word = {in_cond, in_op, 1'b1, in_set, in_offset};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_err    <= 1'b0;
            r_count  <= '0;
        end else begin
            r_err <= w_accept && !w_legal;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + (AW+1)'(1);
                2'b01:   r_occ <= r_occ - (AW+1)'(1);
                default: r_occ <= r_occ;
            endcase
            // Saturate rather than wrap so long runs never report a small count.
            if (w_push && (r_count != {CNT_W{1'b1}})) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Table-driven bench for instr_encoder with an in-order scoreboard on the output side.
module tb_instr_encoder;

    localparam int DEPTH = 2;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [3:0]       in_cond;
    logic             in_imm_sel;
    logic [3:0]       in_cmd;
    logic             in_set;
    logic [3:0]       in_rn;
    logic [3:0]       in_rd;
    logic [11:0]      in_imm12;
    logic [3:0]       in_rm;
    logic [23:0]      in_offset;
    logic [31:0]      instr;
    logic             instr_valid;
    logic             instr_ready;
    logic             err_illegal;
    logic [CNT_W-1:0] instr_count;

    instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_cond(in_cond), .in_imm_sel(in_imm_sel),
        .in_cmd(in_cmd), .in_set(in_set), .in_rn(in_rn), .in_rd(in_rd),
        .in_imm12(in_imm12), .in_rm(in_rm), .in_offset(in_offset),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .err_illegal(err_illegal), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  cond;
        logic        imm_sel;
        logic [3:0]  cmd;
        logic        set;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [11:0] imm12;
        logic [3:0]  rm;
        logic [23:0] offset;
        logic [31:0] exp;
    } vec_t;

    localparam int NVEC = 7;
    vec_t        vec [NVEC];
    logic [31:0] exp_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          model_cnt = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    function automatic vec_t mk(logic [1:0] op, logic [3:0] cond, logic imm_sel, logic [3:0] cmd,
                                logic set, logic [3:0] rn, logic [3:0] rd, logic [11:0] imm12,
                                logic [3:0] rm, logic [23:0] offset, logic [31:0] exp);
        vec_t v;
        v.op = op; v.cond = cond; v.imm_sel = imm_sel; v.cmd = cmd; v.set = set;
        v.rn = rn; v.rd = rd; v.imm12 = imm12; v.rm = rm; v.offset = offset; v.exp = exp;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        in_op = v.op; in_cond = v.cond; in_imm_sel = v.imm_sel; in_cmd = v.cmd;
        in_set = v.set; in_rn = v.rn; in_rd = v.rd; in_imm12 = v.imm12;
        in_rm = v.rm; in_offset = v.offset;
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the bundle.
    task automatic send(input vec_t v, input int max_wait);
        bit ok;
        ok = 1'b0;
        drive(v);
        in_valid = 1'b1;
        for (int c = 0; c < max_wait; c++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                if (v.op != 2'd3) begin
                    exp_q.push_back(v.exp);
                    if (model_cnt != (1 << CNT_W) - 1) model_cnt++;
                end
            end
            @(posedge clk);
            #1;
            if (ok) break;
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles, expected acceptance", max_wait);
        end
    endtask

    // Scoreboard: a pop happens at the next rising edge whenever valid && ready now.
    always @(negedge clk) begin
        if (!rst && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", instr, 32'hxxxxxxxx);
            end else begin
                chk("scoreboard_word", instr, exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec[0] = mk(2'd0, 4'hE, 1'b1, 4'd4,  1'b0, 4'd1, 4'd2, 12'h005, 4'd0, 24'd0, 32'hE2812005);
        vec[1] = mk(2'd1, 4'hE, 1'b1, 4'hC,  1'b1, 4'd3, 4'd4, 12'h010, 4'd0, 24'd0, 32'hE7934010);
        vec[2] = mk(2'd2, 4'hE, 1'b0, 4'd0,  1'b1, 4'd0, 4'd0, 12'h000, 4'd0, 24'h000010, 32'hEB000010);
`ifdef INSTR_ENCODER_CMP_FIXUP_EN
        vec[3] = mk(2'd0, 4'hE, 1'b1, 4'd10, 1'b0, 4'd1, 4'd7, 12'h000, 4'd0, 24'd0, 32'hE3510000);
`else
        vec[3] = mk(2'd0, 4'hE, 1'b1, 4'd10, 1'b0, 4'd1, 4'd7, 12'h000, 4'd0, 24'd0, 32'hE3417000);
`endif
        vec[4] = mk(2'd0, 4'h0, 1'b0, 4'd0,  1'b1, 4'd2, 4'd3, 12'hFFF, 4'd5, 24'd0, 32'h00123005);
        vec[5] = mk(2'd2, 4'h0, 1'b1, 4'hF,  1'b0, 4'hF, 4'hF, 12'hFFF, 4'hF, 24'hABCDEF, 32'h0AABCDEF);
        vec[6] = mk(2'd1, 4'h1, 1'b0, 4'd9,  1'b0, 4'hF, 4'h0, 12'hABC, 4'hA, 24'd0, 32'h152F000A);

        rst = 1'b1; in_valid = 1'b0; instr_ready = 1'b0;
        drive(vec[0]);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_instr", instr, 32'h0);
        chk("reset_instr_valid", 32'(instr_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_err_illegal", 32'(err_illegal), 32'd0);
        chk("reset_instr_count", 32'(instr_count), 32'd0);
        @(posedge clk);
        #1;

        // Single-bundle encodings, each with one-cycle latency into an empty FIFO.
        instr_ready = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            send(vec[i], 5);
            chk($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'd1);
            chk($sformatf("vec%0d_instr", i), instr, vec[i].exp);
            chk($sformatf("vec%0d_count", i), 32'(instr_count), 32'(model_cnt));
        end
        @(posedge clk);
        #1;

        // Illegal class: one-cycle error pulse, nothing queued, count held.
        send(mk(2'd3, 4'hE, 1'b1, 4'd1, 1'b1, 4'd1, 4'd1, 12'h1, 4'd1, 24'd1, 32'h0), 5);
        chk("illegal_err_pulse", 32'(err_illegal), 32'd1);
        chk("illegal_no_valid", 32'(instr_valid), 32'd0);
        chk("illegal_count_held", 32'(instr_count), 32'(model_cnt));
        @(posedge clk);
        #1;
        chk("illegal_err_one_cycle", 32'(err_illegal), 32'd0);

        // Fill the FIFO with the consumer stalled, then hold an extra bundle off.
        instr_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) send(vec[i], 5);
        @(negedge clk);
        chk("full_in_ready_low", 32'(in_ready), 32'd0);
        chk("full_head_word", instr, vec[0].exp);
        @(posedge clk);
        #1;
        fork
            send(vec[2], 20);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("held_in_ready_low", 32'(in_ready), 32'd0);
                    chk("held_head_stable", instr, vec[0].exp);
                end
                @(posedge clk);
                #1;
                instr_ready = 1'b1;
            end
        join
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
        chk("drain_valid_low", 32'(instr_valid), 32'd0);
        chk("drain_count", 32'(instr_count), 32'(model_cnt));

        // Reset on an illegal accept suppresses the error pulse.
        rst = 1'b1;
        drive(mk(2'd3, 4'h0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 12'h0, 4'd0, 24'd0, 32'h0));
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        model_cnt = 0;
        chk("rst_err_suppressed", 32'(err_illegal), 32'd0);

        // Reset with two buffered words discards them.
        instr_ready = 1'b0;
        send(vec[4], 5);
        send(vec[5], 5);
        chk("pre_rst_count", 32'(instr_count), 32'd2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        model_cnt = 0;
        chk("mid_rst_valid", 32'(instr_valid), 32'd0);
        chk("mid_rst_count", 32'(instr_count), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_instr", instr, 32'h0);

        // Counter saturates at all-ones.
        instr_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            send(vec[i % NVEC], 5);
            chk($sformatf("sat_count%0d", i), 32'(instr_count), 32'(model_cnt));
        end
        chk("sat_count_final", 32'(instr_count), 32'((1 << CNT_W) - 1));
        repeat (3) @(posedge clk);
        #1;
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
